// File: rtl/alu_share_pkg.sv
// alu_share_pkg: ALU opcodes, port ids and FSM state type for alu_share_arbiter
package alu_share_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b1000;
  localparam logic PORT_INT = 1'b0;
  localparam logic PORT_BR  = 1'b1;
  typedef enum logic {EMPTY, FULL} state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational AND/OR/ADD/SUB/signed-SLT unit (in1_i, in2_i, ctrl_i -> result_o, zero_o); other codes give 0
module alu import alu_share_pkg::*; #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic [WIDTH-1:0]  in1_i,
  input  logic [WIDTH-1:0]  in2_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [WIDTH-1:0]  result_o,
  output logic              zero_o
);
  logic slt;
  assign slt = $signed(in1_i) < $signed(in2_i);
  assign result_o = ctrl_i == ALU_AND ? in1_i & in2_i :
                    ctrl_i == ALU_OR  ? in1_i | in2_i :
                    ctrl_i == ALU_ADD ? in1_i + in2_i :
                    ctrl_i == ALU_SUB ? in1_i - in2_i :
                    ctrl_i == ALU_SLT ? {{(WIDTH-1){1'b0}}, slt} : '0;
  assign zero_o = result_o == '0;
endmodule

// File: rtl/alu_share_arbiter_rr_arb2.sv
// rr_arb2: two-request round-robin, one-hot gnt_o from req_i, favouring the port not named by last_i
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);
  assign gnt_o = &req_i ? (last_i ? 2'b01 : 2'b10) : req_i;
endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin shares one alu between two valid/ready request ports, one owner-tagged registered result slot with op_count
module alu_share_arbiter import alu_share_pkg::*; #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [WIDTH-1:0]  req_in1_0,
  input  logic [WIDTH-1:0]  req_in1_1,
  input  logic [WIDTH-1:0]  req_in2_0,
  input  logic [WIDTH-1:0]  req_in2_1,
  input  logic [CTRL_W-1:0] req_ctrl_0,
  input  logic [CTRL_W-1:0] req_ctrl_1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero,
  output logic [15:0]       op_count
);
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d, zero_q, zero_d;
  logic [WIDTH-1:0] result_q, result_d, alu_res;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0] gnt;
  logic sel, drain, free, accept, alu_zero;
  rr_arb2 u_arb (.req_i(req_valid), .last_i(last_q), .gnt_o(gnt));
  assign sel = gnt[PORT_BR];
  alu #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) u_alu (
    .in1_i   (sel ? req_in1_1 : req_in1_0),
    .in2_i   (sel ? req_in2_1 : req_in2_0),
    .ctrl_i  (sel ? req_ctrl_1 : req_ctrl_0),
    .result_o(alu_res),
    .zero_o  (alu_zero)
  );
  assign drain = state_q == FULL && rsp_ready[owner_q];
  assign free = state_q == EMPTY || rsp_ready[owner_q];
  assign req_ready = free && !rst ? gnt : 2'b00;
  assign accept = |req_ready;
  always_comb begin
    state_d = accept ? FULL : drain ? EMPTY : state_q;
    owner_d = accept ? sel : owner_q;
    last_d = accept ? sel : last_q;
    result_d = accept ? alu_res : result_q;
    zero_d = accept ? alu_zero : zero_q;
    cnt_d = drain ? cnt_q + 16'd1 : cnt_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      owner_q <= PORT_INT;
      last_q <= PORT_BR;
      result_q <= '0;
      zero_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      result_q <= result_d;
      zero_q <= zero_d;
      cnt_q <= cnt_d;
    end
  end
  assign rsp_valid = state_q == FULL ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result = result_q;
  assign rsp_zero = zero_q;
  assign op_count = cnt_q;
endmodule
